// File: rtl/fc_layer_sched.sv
// fc_layer_sched
//   Address/strobe sequencer for a fully-connected layer. For every sample s
//   and every output o it streams IN_NUM weight/data reads into a MAC, fetches
//   the bias for the last product, waits one cycle for the read pipeline to
//   drain, then writes the result (packed in 16-bit pairs) to the result RAM.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       synchronous reset, active HIGH
//   start       run request, honoured only in IDLE
//   abort       cancels a run in progress
//   out_rdy     result sink accepts a write this cycle
//   busy, done  not-IDLE flag / one-cycle end-of-run pulse
//   w_rd_en, data_rd_en, bias_rd_en   memory read strobes
//   w_addr, data_addr, bias_addr, out_addr   AW-bit addresses
//   acc_clr, acc_en, acc_last         accumulator controls (one cycle after reads)
//   out_wr_en, pack_hi, pair_vld      result write strobe and packing controls
//
// States
//   state    | meaning
//   ST_IDLE  | waiting for start, all strobes low
//   ST_RUN   | one weight/data read per cycle, i = 0..IN_NUM-1
//   ST_DRAIN | last product in flight, no reads
//   ST_WRITE | result write, held while out_rdy = 0
//   ST_DONE  | one-cycle done pulse

module fc_layer_sched #(
    parameter int SPECIES = 42,
    parameter int IN_NUM  = 64,
    parameter int OUT_NUM = 2,
    parameter int AW      = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          out_rdy,
    output logic          busy,
    output logic          done,
    output logic          w_rd_en,
    output logic          data_rd_en,
    output logic [AW-1:0] w_addr,
    output logic [AW-1:0] data_addr,
    output logic [AW-1:0] bias_addr,
    output logic [AW-1:0] out_addr,
    output logic          bias_rd_en,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          acc_last,
    output logic          out_wr_en,
    output logic          pack_hi,
    output logic          pair_vld
);

    localparam int SW = (SPECIES > 1) ? $clog2(SPECIES) : 1;
    localparam int OW = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
    localparam int IW = (IN_NUM  > 1) ? $clog2(IN_NUM)  : 1;

    localparam logic [SW-1:0] S_LAST = SW'(SPECIES - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUT_NUM - 1);
    localparam logic [IW-1:0] I_LAST = IW'(IN_NUM - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] s_q, s_nxt;
    logic [OW-1:0] o_q, o_nxt;
    logic [IW-1:0] i_q, i_nxt;

    // registered-output next values
    logic          busy_d, done_d, rd_d, bias_rd_d, first_d;
    logic          wr_d, pack_hi_d, pair_vld_d;
    logic [AW-1:0] w_addr_d, data_addr_d, bias_addr_d, out_addr_d;

    // marks the read of i = 0, aligned with w_rd_en
    logic          rd_first_q;
    logic          kill;

    assign kill = abort && (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= ST_IDLE;
            s_q   <= '0;
            o_q   <= '0;
            i_q   <= '0;
        end else begin
            state <= state_nxt;
            s_q   <= s_nxt;
            o_q   <= o_nxt;
            i_q   <= i_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_nxt     = s_q;
        o_nxt     = o_q;
        i_nxt     = i_q;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt = ST_RUN;
                    s_nxt     = '0;
                    o_nxt     = '0;
                    i_nxt     = '0;
                end
            end
            ST_RUN: begin
                if (i_q == I_LAST) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    i_nxt = i_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (out_rdy) begin
                    i_nxt = '0;
                    if (o_q == O_LAST) begin
                        o_nxt = '0;
                        if (s_q == S_LAST) begin
                            s_nxt     = '0;
                            state_nxt = ST_DONE;
                        end else begin
                            s_nxt     = s_q + 1'b1;
                            state_nxt = ST_RUN;
                        end
                    end else begin
                        o_nxt     = o_q + 1'b1;
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (kill) begin
            state_nxt = ST_IDLE;
            s_nxt     = '0;
            o_nxt     = '0;
            i_nxt     = '0;
        end
    end

    // Outputs are decoded from the next state/counters and registered, so the
    // strobes seen during a cycle always describe the state of that cycle.
    always_comb begin
        busy_d      = (state_nxt != ST_IDLE);
        done_d      = (state_nxt == ST_DONE);
        rd_d        = (state_nxt == ST_RUN);
        wr_d        = (state_nxt == ST_WRITE);
        bias_rd_d   = 1'b0;
        first_d     = 1'b0;
        pack_hi_d   = 1'b0;
        pair_vld_d  = 1'b0;
        w_addr_d    = '0;
        data_addr_d = '0;
        bias_addr_d = '0;
        out_addr_d  = '0;
        if (rd_d) begin
            w_addr_d    = AW'(o_nxt) * AW'(IN_NUM) + AW'(i_nxt);
            data_addr_d = AW'(s_nxt) * AW'(IN_NUM) + AW'(i_nxt);
            first_d     = (i_nxt == '0);
            if (i_nxt == I_LAST) begin
                bias_rd_d   = 1'b1;
                bias_addr_d = AW'(o_nxt);
            end
        end
        if (wr_d) begin
            out_addr_d = AW'(s_nxt) * AW'(OUT_NUM) + AW'(o_nxt);
            pack_hi_d  = ~o_nxt[0];
            pair_vld_d = o_nxt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            w_rd_en    <= 1'b0;
            data_rd_en <= 1'b0;
            bias_rd_en <= 1'b0;
            rd_first_q <= 1'b0;
            w_addr     <= '0;
            data_addr  <= '0;
            bias_addr  <= '0;
            out_addr   <= '0;
            out_wr_en  <= 1'b0;
            pack_hi    <= 1'b0;
            pair_vld   <= 1'b0;
            acc_en     <= 1'b0;
            acc_clr    <= 1'b0;
            acc_last   <= 1'b0;
        end else begin
            busy       <= busy_d;
            done       <= done_d;
            w_rd_en    <= rd_d;
            data_rd_en <= rd_d;
            bias_rd_en <= bias_rd_d;
            rd_first_q <= first_d;
            w_addr     <= w_addr_d;
            data_addr  <= data_addr_d;
            bias_addr  <= bias_addr_d;
            out_addr   <= out_addr_d;
            out_wr_en  <= wr_d;
            pack_hi    <= pack_hi_d;
            pair_vld   <= pair_vld_d;
            // read data arrives one cycle after the strobe; an abort drops the
            // product still in flight so the MAC sees nothing after the cancel
            acc_en     <= w_rd_en    & ~kill;
            acc_clr    <= rd_first_q & ~kill;
            acc_last   <= bias_rd_en & ~kill;
        end
    end

endmodule

// File: tb/tb_fc_layer_sched.sv
// tb_fc_layer_sched
//   Directed bench for fc_layer_sched (SPECIES=2, IN_NUM=4, OUT_NUM=2).
//   A timeline model builds the expected value of every output for every
//   cycle of a stimulus window; a negedge process compares the DUT against it.

module tb_fc_layer_sched;

    localparam int SPECIES = 2;
    localparam int IN_NUM  = 4;
    localparam int OUT_NUM = 2;
    localparam int AW      = 14;
    localparam int NC      = 80;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, out_rdy;
    logic          busy, done, w_rd_en, data_rd_en, bias_rd_en;
    logic [AW-1:0] w_addr, data_addr, bias_addr, out_addr;
    logic          acc_clr, acc_en, acc_last, out_wr_en, pack_hi, pair_vld;

    fc_layer_sched #(
        .SPECIES(SPECIES), .IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .out_rdy(out_rdy),
        .busy(busy), .done(done), .w_rd_en(w_rd_en), .data_rd_en(data_rd_en),
        .w_addr(w_addr), .data_addr(data_addr), .bias_addr(bias_addr),
        .out_addr(out_addr), .bias_rd_en(bias_rd_en), .acc_clr(acc_clr),
        .acc_en(acc_en), .acc_last(acc_last), .out_wr_en(out_wr_en),
        .pack_hi(pack_hi), .pair_vld(pair_vld)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // stimulus per cycle of a window
    int st_v[NC], ab_v[NC], rd_v[NC], rs_v[NC];
    // expected outputs per cycle
    int e_busy[NC], e_done[NC], e_w_rd[NC], e_d_rd[NC], e_w_addr[NC], e_d_addr[NC];
    int e_b_rd[NC], e_b_addr[NC], e_clr[NC], e_en[NC], e_last[NC];
    int e_wr[NC], e_o_addr[NC], e_hi[NC], e_pair[NC];

    bit chk_on = 1'b0;
    int cur_cyc = 0;
    int cc;

    task automatic chk(input string nm, input int c, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, c, act, exp);
        end
    endtask

    task automatic clear_cycle(input int j);
        e_busy[j] = 0; e_done[j] = 0; e_w_rd[j] = 0; e_d_rd[j] = 0;
        e_w_addr[j] = 0; e_d_addr[j] = 0; e_b_rd[j] = 0; e_b_addr[j] = 0;
        e_clr[j] = 0; e_en[j] = 0; e_last[j] = 0;
        e_wr[j] = 0; e_o_addr[j] = 0; e_hi[j] = 0; e_pair[j] = 0;
    endtask

    task automatic clr_stim();
        for (int j = 0; j < NC; j++) begin
            st_v[j] = 0; ab_v[j] = 0; rd_v[j] = 1; rs_v[j] = 0;
        end
    endtask

    task automatic put_write(input int k, input int s, input int o);
        e_wr[k]     = 1;
        e_o_addr[k] = s * OUT_NUM + o;
        e_hi[k]     = (o % 2 == 0) ? 1 : 0;
        e_pair[k]   = (o % 2 == 1) ? 1 : 0;
    endtask

    // Lay out each accepted run on the timeline: reads land in the cycle after
    // start, products one cycle after their reads, one drain cycle, a write
    // stretched by out_rdy=0, done after the last write. An abort or reset
    // inside a run wipes everything after its cycle.
    task automatic plan(input int len);
        int c, k, t, endc;
        bit found;
        for (int j = 0; j < NC; j++) clear_cycle(j);
        c = 0;
        while (c < len) begin
            if (st_v[c] != 0 && ab_v[c] == 0 && rs_v[c] == 0) begin
                t = c;
                k = c + 1;
                for (int s = 0; s < SPECIES; s++) begin
                    for (int o = 0; o < OUT_NUM; o++) begin
                        for (int i = 0; i < IN_NUM; i++) begin
                            e_w_rd[k]   = 1;
                            e_d_rd[k]   = 1;
                            e_w_addr[k] = o * IN_NUM + i;
                            e_d_addr[k] = s * IN_NUM + i;
                            if (i == IN_NUM - 1) begin
                                e_b_rd[k]   = 1;
                                e_b_addr[k] = o;
                            end
                            e_en[k+1]   = 1;
                            e_clr[k+1]  = (i == 0) ? 1 : 0;
                            e_last[k+1] = (i == IN_NUM - 1) ? 1 : 0;
                            k++;
                        end
                        k++;
                        while (rd_v[k] == 0 && k < NC - 4) begin
                            put_write(k, s, o);
                            k++;
                        end
                        put_write(k, s, o);
                        k++;
                    end
                end
                e_done[k] = 1;
                for (int j = t + 1; j <= k; j++) e_busy[j] = 1;
                endc  = k;
                found = 1'b0;
                for (int a = t + 1; a <= k; a++) begin
                    if (!found && (ab_v[a] != 0 || rs_v[a] != 0)) begin
                        found = 1'b1;
                        endc  = a;
                        for (int j = a + 1; j <= k + 1 && j < NC; j++) clear_cycle(j);
                    end
                end
                c = endc + 1;
            end else begin
                c++;
            end
        end
    endtask

    task automatic drive(input int c);
        start   = (st_v[c] != 0);
        abort   = (ab_v[c] != 0);
        out_rdy = (rd_v[c] != 0);
        rst_n   = (rs_v[c] != 0);
    endtask

    task automatic run_window(input int len);
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cur_cyc = 0;
        drive(0);
        chk_on = 1'b1;
        for (int c = 0; c < len - 1; c++) begin
            @(posedge clk);
            #1;
            cur_cyc = c + 1;
            drive(c + 1);
        end
        @(negedge clk);
        #1;
        chk_on = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cc = cur_cyc;
            chk("busy",       cc, int'(busy),       e_busy[cc]);
            chk("done",       cc, int'(done),       e_done[cc]);
            chk("w_rd_en",    cc, int'(w_rd_en),    e_w_rd[cc]);
            chk("data_rd_en", cc, int'(data_rd_en), e_d_rd[cc]);
            chk("w_addr",     cc, int'(w_addr),     e_w_addr[cc]);
            chk("data_addr",  cc, int'(data_addr),  e_d_addr[cc]);
            chk("bias_rd_en", cc, int'(bias_rd_en), e_b_rd[cc]);
            chk("bias_addr",  cc, int'(bias_addr),  e_b_addr[cc]);
            chk("acc_clr",    cc, int'(acc_clr),    e_clr[cc]);
            chk("acc_en",     cc, int'(acc_en),     e_en[cc]);
            chk("acc_last",   cc, int'(acc_last),   e_last[cc]);
            chk("out_wr_en",  cc, int'(out_wr_en),  e_wr[cc]);
            chk("out_addr",   cc, int'(out_addr),   e_o_addr[cc]);
            chk("pack_hi",    cc, int'(pack_hi),    e_hi[cc]);
            chk("pair_vld",   cc, int'(pair_vld),   e_pair[cc]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; out_rdy = 1'b1;

        // nominal run with a stray start while busy
        clr_stim();
        st_v[0] = 1; st_v[10] = 1;
        plan(30);
        chk("pin_w_addr4",   -1, e_w_addr[4], 3);
        chk("pin_clr2",      -1, e_clr[2], 1);
        chk("pin_last5",     -1, e_last[5], 1);
        chk("pin_bias4",     -1, e_b_rd[4], 1);
        chk("pin_wr6",       -1, e_wr[6], 1);
        chk("pin_oaddr12",   -1, e_o_addr[12], 1);
        chk("pin_oaddr18",   -1, e_o_addr[18], 2);
        chk("pin_hi18",      -1, e_hi[18], 1);
        chk("pin_pair24",    -1, e_pair[24], 1);
        chk("pin_daddr13",   -1, e_d_addr[13], 4);
        chk("pin_done25",    -1, e_done[25], 1);
        chk("pin_busy26",    -1, e_busy[26], 0);
        run_window(30);

        // backpressure on the first write
        clr_stim();
        st_v[0] = 1; rd_v[6] = 0; rd_v[7] = 0; rd_v[8] = 0;
        plan(32);
        chk("pin_bp_wr8",    -1, e_wr[8], 1);
        chk("pin_bp_oaddr15",-1, e_o_addr[15], 1);
        chk("pin_bp_done28", -1, e_done[28], 1);
        run_window(32);

        // abort mid-run, then restart
        clr_stim();
        st_v[0] = 1; ab_v[8] = 1; st_v[12] = 1;
        plan(42);
        chk("pin_ab_rd9",    -1, e_w_rd[9], 0);
        chk("pin_ab_en9",    -1, e_en[9], 0);
        chk("pin_ab_rd13",   -1, e_w_rd[13], 1);
        chk("pin_ab_done25", -1, e_done[25], 0);
        chk("pin_ab_done37", -1, e_done[37], 1);
        run_window(42);

        // reset mid-run
        clr_stim();
        st_v[0] = 1; rs_v[15] = 1;
        plan(28);
        chk("pin_rs_busy15", -1, e_busy[15], 1);
        chk("pin_rs_busy16", -1, e_busy[16], 0);
        run_window(28);

        // start+abort together in IDLE, then abort during WRITE
        clr_stim();
        st_v[0] = 1; ab_v[0] = 1; st_v[3] = 1; ab_v[9] = 1;
        plan(16);
        chk("pin_sa_busy1",  -1, e_busy[1], 0);
        chk("pin_sa_rd4",    -1, e_w_rd[4], 1);
        chk("pin_sa_wr9",    -1, e_wr[9], 1);
        chk("pin_sa_busy10", -1, e_busy[10], 0);
        run_window(16);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fc_layer_sched.md
FC_LAYER_SCHED -- requirements
Module: fc_layer_sched

Interface
REQ-001 The block SHALL have parameter SPECIES, default 42, meaning the number of input vectors (samples) processed per run.
REQ-002 The block SHALL have parameter IN_NUM, default 64, meaning the inputs per vector and the MAC length per output.
REQ-003 The block SHALL have parameter OUT_NUM, default 2, meaning the outputs per vector; it is even.
REQ-004 The block SHALL have parameter AW, default 14, meaning the width of all address outputs.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-008 The block SHALL have port abort, input, 1 bit: cancels a run.
REQ-009 The block SHALL have port out_rdy, input, 1 bit: the result sink accepts a write this cycle.
REQ-010 The block SHALL have ports busy and done, outputs, 1 bit each: busy is high when not in IDLE; done is a one-cycle end-of-run pulse.
REQ-011 The block SHALL have ports w_rd_en and data_rd_en, outputs, 1 bit each: read strobes for the weight ROM and the data RAM.
REQ-012 The block SHALL have ports w_addr, data_addr, bias_addr and out_addr, outputs, AW bits each: the weight, data, bias and result addresses.
REQ-013 The block SHALL have port bias_rd_en, output, 1 bit: read strobe for the bias ROM.
REQ-014 The block SHALL have ports acc_clr, acc_en and acc_last, outputs, 1 bit each: accumulator controls.
REQ-015 The block SHALL have port out_wr_en, output, 1 bit: write strobe to the result RAM.
REQ-016 The block SHALL have ports pack_hi and pair_vld, outputs, 1 bit each: 16-bit result packing controls.

Function
REQ-017 The block SHALL use counters s (0..SPECIES-1), o (0..OUT_NUM-1) and i (0..IN_NUM-1).
REQ-018 The block SHALL implement FSM states IDLE, RUN, DRAIN, WRITE and DONE.
REQ-019 IDLE SHALL transition to RUN on start=1, clearing s, o and i.
REQ-020 In RUN, the block SHALL assert w_rd_en and data_rd_en every cycle, with w_addr=o*IN_NUM+i and data_addr=s*IN_NUM+i, and increment i.
REQ-021 When i=IN_NUM-1, the block SHALL assert bias_rd_en with bias_addr=o and go to DRAIN.
REQ-022 Memory read latency is 1 cycle; acc_en SHALL equal w_rd_en delayed by 1 cycle.
REQ-023 acc_clr SHALL be high together with acc_en for the product of i=0.
REQ-024 acc_last SHALL be high together with acc_en for the product of i=IN_NUM-1, coincident with the bias being valid.
REQ-025 DRAIN SHALL last 1 cycle, with no reads, and then go to WRITE.
REQ-026 In WRITE, the block SHALL assert out_wr_en with out_addr=s*OUT_NUM+o.
REQ-027 In WRITE, pack_hi SHALL be 1 when o is even and 0 when o is odd.
REQ-028 In WRITE, pair_vld SHALL be 1 only when o is odd.
REQ-029 If out_rdy=0 in WRITE, the block SHALL hold WRITE with all outputs stable; the write completes in the first cycle with out_rdy=1.
REQ-030 After the write completes, the block SHALL wrap o to 0 and increment s when o=OUT_NUM-1, otherwise increment o.
REQ-031 After the write completes, the block SHALL clear i and go to RUN, or go to DONE if s=SPECIES-1 and o=OUT_NUM-1.
REQ-032 DONE SHALL pulse done for 1 cycle and then go to IDLE.
REQ-033 With out_rdy held at 1, each output SHALL take IN_NUM+2 cycles.
REQ-034 With out_rdy held at 1 and start seen at cycle 0, done SHALL be high at cycle SPECIES*OUT_NUM*(IN_NUM+2)+1.
REQ-035 start outside IDLE SHALL be ignored.
REQ-036 start and abort high together in IDLE SHALL leave the block in IDLE.
REQ-037 abort=1 in any non-IDLE state SHALL force IDLE on the next cycle, with all strobes low from that cycle, no done pulse, and the counters cleared.
REQ-038 Any pending delayed acc_en/acc_last SHALL be suppressed after abort.
REQ-039 Address arithmetic SHALL be unsigned and truncated to AW bits; the default parameters never exceed AW.
REQ-040 All strobes and addresses SHALL be registered outputs.
REQ-041 Outside RUN and WRITE, the address outputs SHALL be 0.

Reset
REQ-042 With rst_n=1 at a clock edge, the FSM SHALL go to IDLE and s, o, i SHALL be cleared.
REQ-043 With rst_n=1 at a clock edge, busy, done, w_rd_en, data_rd_en, bias_rd_en, acc_clr, acc_en, acc_last, out_wr_en, pack_hi and pair_vld SHALL be 0, and all address outputs SHALL be 0.
REQ-044 Reset asserted mid-run SHALL override abort and start, produce no done pulse, and discard the run.

Verification
REQ-045 Nominal run: SPECIES=2, IN_NUM=4, OUT_NUM=2, out_rdy=1, start at cycle 0 -> w_addr 0,1,2,3 at cycles 1-4 -> out_wr_en with out_addr=0 at cycle 6 -> out_addr 1, 2, 3 at cycles 12, 18, 24 -> done at cycle 25 -> busy low at cycle 26.
REQ-046 Accumulator timing: same run -> acc_clr at cycle 2, acc_last and bias valid at cycle 5 with bias_addr=0 issued at cycle 4, data_addr for s=1 running 4..7.
REQ-047 Backpressure: out_rdy=0 for 3 cycles from the first WRITE -> WRITE held with out_addr=0 stable -> the whole schedule shifts by 3 -> done at cycle 28.
REQ-048 Abort: abort=1 at cycle 8 -> all strobes low at cycle 9 -> no done -> a new start at cycle 12 restarts with w_addr=0, data_addr=0.
REQ-049 Packing and start-ignore: pack_hi=1 / pair_vld=0 on out_addr 0 and 2; pack_hi=0 / pair_vld=1 on out_addr 1 and 3; a start pulse at cycle 10 has no effect.
REQ-050 Reset mid-run: rst_n=1 at cycle 15 -> every output is 0 and busy=0 at cycle 16, and there is no done pulse.
